// File: rtl/ervp_product_accumulator_if.sv
// Handshake bundle for ervp_product_accumulator: product input stream and result output.
// Ports: in_valid/in_ready/in_product/in_last (product side),
//        out_valid/out_ready/out_result/out_count/out_ovf (result side).
interface ervp_product_accumulator_if #(
  parameter int BW_PRODUCT = 64,
  parameter int BW_RESULT  = 32,
  parameter int BW_COUNT   = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BW_PRODUCT-1:0] in_product;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [BW_RESULT-1:0]  out_result;
  logic [BW_COUNT-1:0]   out_count;
  logic                  out_ovf;

  // master: the environment that feeds products and drains results
  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_count, out_ovf
  );

  // slave: the accumulator itself
  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_result, out_count, out_ovf
  );
endinterface

// File: rtl/ervp_product_accumulator.sv
// Sums a frame of signed products into a BW_ACC-bit accumulator and presents the
// scaled, narrowed sum with term count and overflow flag on a valid/ready output.
// Latency: result valid 1 cycle after the in_last beat is accepted.
// Backpressure: in_ready low while a result is held (OUTPUT) or clear is high.
// Ports: clk, rstnn (async active-low), clear (sync abort), bus (slave modport).
// Option: ERVP_PRODUCT_ACC_SATURATE_EN clamps the result instead of truncating it.
module ervp_product_accumulator #(
  parameter int BW_PRODUCT   = 64,
  parameter int BW_ACC       = 72,
  parameter int BW_RESULT    = 32,
  parameter int RESULT_SHIFT = 0,
  parameter int BW_COUNT     = 16
) (
  input  logic                         clk,
  input  logic                         rstnn,
  input  logic                         clear,
  ervp_product_accumulator_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t               state, state_next;
  logic [BW_ACC-1:0]    acc, acc_next;
  logic [BW_COUNT-1:0]  count, count_next;
  logic                 ovf, ovf_next;
  logic [BW_RESULT-1:0] result_q, result_next;
  logic [BW_COUNT-1:0]  count_q;
  logic                 ovf_q;
  logic                 load_out;
  logic                 accept;
  logic [BW_ACC-1:0]    prod_ext;
  logic [BW_ACC-1:0]    sum;
  logic                 add_ovf;
`ifdef ERVP_PRODUCT_ACC_SATURATE_EN
  // sign the true (unwrapped) sum had at the most recent wrap; sets clamp direction
  logic                 ovf_sign, ovf_sign_next;
  logic signed [BW_ACC-1:0] scaled;
  localparam logic [BW_RESULT-1:0] RES_MAX = {1'b0, {(BW_RESULT-1){1'b1}}};
  localparam logic [BW_RESULT-1:0] RES_MIN = {1'b1, {(BW_RESULT-1){1'b0}}};
`endif

  assign bus.in_ready   = (state != OUTPUT) && !clear;
  assign accept         = bus.in_valid && bus.in_ready;
  assign prod_ext       = {{(BW_ACC-BW_PRODUCT){bus.in_product[BW_PRODUCT-1]}}, bus.in_product};
  assign sum            = acc + prod_ext;
  // wrap: both operands share a sign that the sum does not
  assign add_ovf        = (acc[BW_ACC-1] == prod_ext[BW_ACC-1]) && (sum[BW_ACC-1] != acc[BW_ACC-1]);
  assign bus.out_valid  = (state == OUTPUT);
  assign bus.out_result = result_q;
  assign bus.out_count  = count_q;
  assign bus.out_ovf    = ovf_q;

  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    ovf_next   = ovf;
    load_out   = 1'b0;
`ifdef ERVP_PRODUCT_ACC_SATURATE_EN
    ovf_sign_next = ovf_sign;
`endif
    if (clear) begin
      state_next = IDLE;
      acc_next   = '0;
      count_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_next   = prod_ext;
            count_next = BW_COUNT'(1);
            ovf_next   = 1'b0;
`ifdef ERVP_PRODUCT_ACC_SATURATE_EN
            ovf_sign_next = 1'b0;
`endif
            state_next = bus.in_last ? OUTPUT : ACCUM;
            load_out   = bus.in_last;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_next   = sum;
            count_next = (count == '1) ? count : count + BW_COUNT'(1);
            ovf_next   = ovf | add_ovf;
`ifdef ERVP_PRODUCT_ACC_SATURATE_EN
            if (add_ovf) ovf_sign_next = prod_ext[BW_ACC-1];
`endif
            if (bus.in_last) begin
              state_next = OUTPUT;
              load_out   = 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            state_next = IDLE;
            acc_next   = '0;
            count_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Result is formed from acc_next so the final product is already included.
`ifdef ERVP_PRODUCT_ACC_SATURATE_EN
  always_comb begin
    scaled = $signed(acc_next) >>> RESULT_SHIFT;
    if (ovf_next) begin
      result_next = ovf_sign_next ? RES_MIN : RES_MAX;
    end else if (scaled[BW_ACC-1:BW_RESULT-1] != {(BW_ACC-BW_RESULT+1){scaled[BW_ACC-1]}}) begin
      result_next = scaled[BW_ACC-1] ? RES_MIN : RES_MAX;
    end else begin
      result_next = scaled[BW_RESULT-1:0];
    end
  end
`else
  always_comb begin
    result_next = BW_RESULT'($signed(acc_next) >>> RESULT_SHIFT);
  end
`endif

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      result_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef ERVP_PRODUCT_ACC_SATURATE_EN
      ovf_sign <= 1'b0;
`endif
    end else begin
      state <= state_next;
      acc   <= acc_next;
      count <= count_next;
      ovf   <= ovf_next;
`ifdef ERVP_PRODUCT_ACC_SATURATE_EN
      ovf_sign <= ovf_sign_next;
`endif
      if (load_out) begin
        result_q <= result_next;
        count_q  <= count_next;
        ovf_q    <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_ervp_product_accumulator.sv
// Directed bench: two accumulators (RESULT_SHIFT 0 and 2) share one stimulus stream;
// each output is checked against hand-computed values.
module tb_ervp_product_accumulator;
  logic        clk = 1'b0;
  logic        rstnn = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_product = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  int          passes = 0;
  int          total = 0;
  logic [31:0] held;

  always #5 clk = ~clk;

  ervp_product_accumulator_if #(.BW_PRODUCT(64), .BW_RESULT(32), .BW_COUNT(16)) bus0 ();
  ervp_product_accumulator_if #(.BW_PRODUCT(64), .BW_RESULT(32), .BW_COUNT(16)) bus2 ();

  assign bus0.in_valid   = in_valid;
  assign bus0.in_product = in_product;
  assign bus0.in_last    = in_last;
  assign bus0.out_ready  = out_ready;
  assign bus2.in_valid   = in_valid;
  assign bus2.in_product = in_product;
  assign bus2.in_last    = in_last;
  assign bus2.out_ready  = out_ready;

  ervp_product_accumulator #(.RESULT_SHIFT(0)) dut0 (.clk(clk), .rstnn(rstnn), .clear(clear), .bus(bus0));
  ervp_product_accumulator #(.RESULT_SHIFT(2)) dut2 (.clk(clk), .rstnn(rstnn), .clear(clear), .bus(bus2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] p, input logic l);
    in_valid = 1'b1; in_product = p; in_last = l;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus0.in_ready), 64'd1);
    check("rst_out_result", 64'(bus0.out_result), 64'd0);
    check("rst_out_count", 64'(bus0.out_count), 64'd0);
    check("rst_out_ovf", 64'(bus0.out_ovf), 64'd0);
    step();
    rstnn = 1'b1;
    step();

    // 1: 3, -5, 7 -> 5
    beat(64'd3, 1'b0);
    check("t1_no_early_valid", 64'(bus0.out_valid), 64'd0);
    beat(-64'sd5, 1'b0);
    beat(64'd7, 1'b1);
    check("t1_out_valid", 64'(bus0.out_valid), 64'd1);
    check("t1_result", 64'(bus0.out_result), 64'd5);
    check("t1_result_sh2", 64'(bus2.out_result), 64'd1);
    check("t1_count", 64'(bus0.out_count), 64'd3);
    check("t1_ovf", 64'(bus0.out_ovf), 64'd0);
    check("t1_in_ready", 64'(bus0.in_ready), 64'd0);
    handshake();
    check("t1_valid_drop", 64'(bus0.out_valid), 64'd0);

    // 2: single -8
    beat(-64'sd8, 1'b1);
    check("t2_result", 64'(bus0.out_result), 64'hFFFF_FFF8);
    check("t2_result_sh2", 64'(bus2.out_result), 64'hFFFF_FFFE);
    check("t2_count", 64'(bus2.out_count), 64'd1);
    handshake();

    // 3: 2^40 + 2^40 exceeds the 32-bit result range
    beat(64'd1 << 40, 1'b0);
    beat(64'd1 << 40, 1'b1);
`ifdef ERVP_PRODUCT_ACC_SATURATE_EN
    check("t3_result", 64'(bus0.out_result), 64'h7FFF_FFFF);
    check("t3_result_sh2", 64'(bus2.out_result), 64'h7FFF_FFFF);
`else
    check("t3_result", 64'(bus0.out_result), 64'h0);
    check("t3_result_sh2", 64'(bus2.out_result), 64'h0);
`endif
    check("t3_count", 64'(bus0.out_count), 64'd2);
    check("t3_ovf", 64'(bus0.out_ovf), 64'd0);
    held = bus0.out_result;

    // 4: hold for 5 cycles while a product is offered
    in_valid = 1'b1; in_product = 64'd100; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold_valid", 64'(bus0.out_valid), 64'd1);
      check("t4_hold_result", 64'(bus0.out_result), 64'(held));
      check("t4_hold_count", 64'(bus0.out_count), 64'd2);
      check("t4_in_ready", 64'(bus0.in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_post_hs_valid", 64'(bus0.out_valid), 64'd0);
    check("t4_post_hs_ready", 64'(bus0.in_ready), 64'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("t4_new_valid", 64'(bus0.out_valid), 64'd1);
    check("t4_new_result", 64'(bus0.out_result), 64'd100);
    check("t4_new_result_sh2", 64'(bus2.out_result), 64'd25);
    check("t4_new_count", 64'(bus0.out_count), 64'd1);
    handshake();

    // 5: clear drops a partial frame and blocks the beat presented with it
    beat(64'd10, 1'b0);
    beat(64'd20, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_product = 64'd999; in_last = 1'b1;
    #1;
    check("t5_clear_ready", 64'(bus0.in_ready), 64'd0);
    step();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("t5_clear_valid", 64'(bus0.out_valid), 64'd0);
    beat(64'd1, 1'b1);
    check("t5_result", 64'(bus0.out_result), 64'd1);
    check("t5_result_sh2", 64'(bus2.out_result), 64'd0);
    check("t5_count", 64'(bus0.out_count), 64'd1);
    handshake();

    // 6: asynchronous reset mid-ACCUM and mid-OUTPUT
    beat(64'd10, 1'b0);
    #2 rstnn = 1'b0;
    #1;
    check("t6a_result", 64'(bus0.out_result), 64'd0);
    check("t6a_count", 64'(bus0.out_count), 64'd0);
    check("t6a_in_ready", 64'(bus0.in_ready), 64'd1);
    step();
    rstnn = 1'b1;
    beat(64'd5, 1'b1);
    check("t6b_valid_before", 64'(bus0.out_valid), 64'd1);
    #2 rstnn = 1'b0;
    #1;
    check("t6b_valid", 64'(bus0.out_valid), 64'd0);
    check("t6b_result", 64'(bus0.out_result), 64'd0);
    check("t6b_count", 64'(bus0.out_count), 64'd0);
    check("t6b_ovf", 64'(bus0.out_ovf), 64'd0);
    check("t6b_in_ready", 64'(bus0.in_ready), 64'd1);
    step();
    rstnn = 1'b1;
    beat(64'd4, 1'b0);
    beat(64'd4, 1'b1);
    check("t6c_result", 64'(bus0.out_result), 64'd8);
    check("t6c_count", 64'(bus0.out_count), 64'd2);
    handshake();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  // absolute bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout passed=%0d total=%0d", passes, total);
    $fatal(1, "timeout");
  end
endmodule
